dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
- Controller for the 2-way, 16-set, 256-bit-line data cache tag/data SRAM.
- It is the initiator on the SRAM lookup/write interface: it presents index, tag and line, consumes hit, victim tag and victim data, and drives enable/write.
- It bridges the 32-bit CPU load/store port to a 256-bit line-wide memory port, with write-back, write-allocate miss handling and stall generation.

Parameters:
- ADDR_W, 32, CPU/memory byte-address width
- WORD_W, 32, CPU data word width
- LINE_W, 256, cache line width (8 words, 32 B)
- IDX_W, 4, set index width (16 sets)
- TAG_W, 23, address tag width; SRAM tag word = TAG_W+2 (bit24 valid, bit23 dirty, [22:0] tag)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- cpu_addr_i  in  32  byte address: tag=[31:9], index=[8:5], word offset=[4:2]
- cpu_data_i  in  32  store data
- cpu_MemRead_i  in  1  load request
- cpu_MemWrite_i  in  1  store request
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  CPU must hold request while high
- sram_addr_o  out  4  set index
- sram_tag_o  out  25  {valid,dirty,tag}
- sram_data_o  out  256  line to write
- sram_enable_o  out  1  lookup/access
- sram_write_o  out  1  write line
- sram_tag_i  in  25  hit tag, or LRU victim tag on miss
- sram_data_i  in  256  hit line, or victim line on miss
- sram_hit_i  in  1  tag match and valid
- mem_addr_o  out  32  line-aligned address ([4:0]=0)
- mem_data_o  out  256  write-back line
- mem_enable_o  out  1  memory request, level
- mem_write_o  out  1  1=write-back, 0=refill
- mem_data_i  in  256  refill line
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Reset (rst_i low, async)
  - state=IDLE; victim/refill registers cleared.
  - cpu_stall_o=0, mem_enable_o=0, mem_write_o=0, sram_write_o=0, sram_enable_o=0, cpu_data_o=0.
  - Reset mid-transaction abandons it immediately; a later mem_ack_i is ignored in IDLE.
- Request: req = cpu_MemRead_i | cpu_MemWrite_i. If both are high, the access is treated as a write.
- IDLE
  - sram_enable_o=req; sram_addr_o=index; sram_tag_o[22:0]=addr tag.
  - Read hit: cpu_data_o = sram_data_i word[offset], combinational. Stall 0, zero-cycle latency.
  - Write hit: same cycle, sram_write_o=1; sram_data_o = sram_data_i with word[offset] replaced by cpu_data_i; sram_tag_o={1,1,tag}. Stall 0.
  - Miss: cpu_stall_o=1 combinationally. Capture victim tag and line.
    - Victim valid&dirty -> WRITEBACK.
    - Otherwise -> REFILL.
- WRITEBACK
  - mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag[22:0],index,5'b0}, mem_data_o=victim line.
  - sram_enable_o=0. Hold until mem_ack_i, then -> REFILL.
- REFILL
  - mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag,index,5'b0}.
  - On mem_ack_i: register mem_data_i, -> UPDATE.
- UPDATE (one cycle)
  - sram_enable_o=1, sram_write_o=1, sram_tag_o={1,0,req tag}, sram_data_o=refill line. -> IDLE.
- Return to IDLE: the held request is looked up again and hits. Stores merge on this re-lookup (write-allocate).
- Stall: high from the miss-detect cycle through UPDATE; low in the re-lookup hit cycle.
  - Clean miss: stall falls 2 cycles after the mem_ack_i cycle.
- mem_enable_o drops in the cycle after ack. Ack in IDLE/UPDATE is ignored.
- Address bits [1:0] are ignored; accesses are word-aligned.

Optional Feature:
- DCACHE_STATS_EN defined:
  - Adds hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - Counts first-lookup hits and misses; re-lookups after a refill are not counted.
  - Wrap at 2^32; cleared by reset.
- DCACHE_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package dcache_pkg:
  - width localparams
  - tag-word bit positions VALID_BIT=24, DIRTY_BIT=23
  - state enum {IDLE, WRITEBACK, REFILL, UPDATE}
  - address field slice constants
- Sub-module dcache_line_merge (combinational):
  - extracts word[offset] from a 256-bit line
  - inserts a 32-bit word at offset
- FSM and datapath stay in dcache_ctrl.

Test Plan:
- Test conditions: memory model acks 10 cycles after mem_enable_o rises; SRAM model matches the 2-way LRU behaviour.
- Reset, then load 0x0000_0040 (cold) -> stall=1; REFILL request at mem_addr_o=0x40, write=0; UPDATE tag 0x1000000; stall drops 2 cycles after ack; cpu_data_o = word0 of mem line.
- Load 0x0000_0044 next -> hit, stall never rises, cpu_data_o = word1, no memory activity.
- Store 0xDEADBEEF to 0x0000_0048 -> same-cycle sram_write_o=1, tag bit23=1, line word2 = 0xDEADBEEF, stall 0.
- Loads to 0x0000_0240, then 0x0000_0440 (same set 2, LRU evicts dirty 0x40 line) -> WRITEBACK to 0x40 with word2 = 0xDEADBEEF, then REFILL 0x440. Stall spans both transactions.
- Store miss to 0x0000_0A64 -> refill, re-lookup merges word1, tag {1,1,tag}, stall falls 1 cycle after UPDATE.
- rst_i low mid-REFILL -> mem_enable_o=0 and stall=0 immediately; stray ack afterwards has no effect. With DCACHE_STATS_EN defined, counters read 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared widths, tag-word layout, address slicing and FSM states for the
// data cache controller.
package dcache_pkg;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int LINE_W = 256;
    localparam int IDX_W  = 4;
    localparam int TAG_W  = 23;
    localparam int STAG_W = TAG_W + 2;
    localparam int OFF_W  = 3;
    localparam int LOFF_W = 5;

    localparam int VALID_BIT = 24;
    localparam int DIRTY_BIT = 23;

    localparam int TAG_LSB = 9;
    localparam int IDX_LSB = 5;
    localparam int OFF_LSB = 2;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL,
        UPDATE
    } state_e;

endpackage

// File: rtl/dcache_line_merge.sv
// Word extract / word insert on a 256-bit cache line.
module dcache_line_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] i_line,
    input  logic [OFF_W-1:0]  i_off,
    input  logic [WORD_W-1:0] i_word,
    output logic [WORD_W-1:0] o_word,
    output logic [LINE_W-1:0] o_line
);

    assign o_word = i_line[i_off*WORD_W +: WORD_W];

    always_comb begin
        o_line = i_line;
        o_line[i_off*WORD_W +: WORD_W] = i_word;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate controller for the 2-way data cache SRAM.
// Define DCACHE_STATS_EN to add first-lookup hit/miss counters.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [WORD_W-1:0] cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [WORD_W-1:0] cpu_data_o,
    output logic              cpu_stall_o,
    output logic [IDX_W-1:0]  sram_addr_o,
    output logic [STAG_W-1:0] sram_tag_o,
    output logic [LINE_W-1:0] sram_data_o,
    output logic              sram_enable_o,
    output logic              sram_write_o,
    input  logic [STAG_W-1:0] sram_tag_i,
    input  logic [LINE_W-1:0] sram_data_i,
    input  logic              sram_hit_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    state_e              r_state;
    state_e              w_next;
    logic [TAG_W-1:0]    r_vic_tag;
    logic [LINE_W-1:0]   r_vic_line;
    logic [LINE_W-1:0]   r_fill_line;

    logic                w_req;
    logic                w_wr;
    logic                w_miss;
    logic                w_vic_dirty;
    logic [TAG_W-1:0]    w_tag;
    logic [IDX_W-1:0]    w_idx;
    logic [OFF_W-1:0]    w_off;
    logic [WORD_W-1:0]   w_word;
    logic [LINE_W-1:0]   w_merged;
    logic                w_unused;

    assign w_req  = cpu_MemRead_i | cpu_MemWrite_i;
    assign w_wr   = cpu_MemWrite_i;
    assign w_tag  = cpu_addr_i[TAG_LSB +: TAG_W];
    assign w_idx  = cpu_addr_i[IDX_LSB +: IDX_W];
    assign w_off  = cpu_addr_i[OFF_LSB +: OFF_W];
    assign w_miss = (r_state == IDLE) & w_req & ~sram_hit_i;
    assign w_vic_dirty = sram_tag_i[VALID_BIT] & sram_tag_i[DIRTY_BIT];
    assign w_unused = ^cpu_addr_i[1:0];

    dcache_line_merge u_merge (
        .i_line (sram_data_i),
        .i_off  (w_off),
        .i_word (cpu_data_i),
        .o_word (w_word),
        .o_line (w_merged)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= IDLE;
            r_vic_tag   <= '0;
            r_vic_line  <= '0;
            r_fill_line <= '0;
        end else begin
            r_state <= w_next;
            if (w_miss) begin
                r_vic_tag  <= sram_tag_i[TAG_W-1:0];
                r_vic_line <= sram_data_i;
            end
            if (r_state == REFILL && mem_ack_i) begin
                r_fill_line <= mem_data_i;
            end
        end
    end

    // Outputs are forced idle while reset is held, even with a request pending.
    always_comb begin
        w_next        = r_state;
        cpu_data_o    = '0;
        cpu_stall_o   = 1'b0;
        sram_addr_o   = w_idx;
        sram_tag_o    = {2'b00, w_tag};
        sram_data_o   = '0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        mem_enable_o  = 1'b0;
        mem_write_o   = 1'b0;
        if (rst_i) begin
            unique case (r_state)
                IDLE: begin
                    sram_enable_o = w_req;
                    sram_tag_o    = {w_wr, w_wr, w_tag};
                    if (w_req && sram_hit_i) begin
                        if (w_wr) begin
                            sram_write_o = 1'b1;
                            sram_data_o  = w_merged;
                        end else begin
                            cpu_data_o = w_word;
                        end
                    end else if (w_req) begin
                        cpu_stall_o = 1'b1;
                        w_next = w_vic_dirty ? WRITEBACK : REFILL;
                    end
                end
                WRITEBACK: begin
                    cpu_stall_o  = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_write_o  = 1'b1;
                    mem_addr_o   = {r_vic_tag, w_idx, {LOFF_W{1'b0}}};
                    mem_data_o   = r_vic_line;
                    if (mem_ack_i) begin
                        w_next = REFILL;
                    end
                end
                REFILL: begin
                    cpu_stall_o  = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_addr_o   = {w_tag, w_idx, {LOFF_W{1'b0}}};
                    if (mem_ack_i) begin
                        w_next = UPDATE;
                    end
                end
                UPDATE: begin
                    cpu_stall_o   = 1'b1;
                    sram_enable_o = 1'b1;
                    sram_write_o  = 1'b1;
                    sram_tag_o    = {2'b10, w_tag};
                    sram_data_o   = r_fill_line;
                    w_next        = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic        r_relook;
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // The lookup right after UPDATE replays a request already counted as a miss.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_relook   <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_relook <= (r_state == UPDATE);
            if (r_state == IDLE && w_req && sram_hit_i && !r_relook) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif

endmodule
